// File: rtl/game_bus_pkg.sv
// Shared types and address map for the game data-bus arbiter.
package game_bus_pkg;

    // Inclusive region bounds (byte addresses)
    localparam int unsigned MEM_LO = 0;
    localparam int unsigned MEM_HI = 999;
    localparam int unsigned PTR_LO = 1000;
    localparam int unsigned PTR_HI = 1004;
    localparam int unsigned ENM_LO = 1008;
    localparam int unsigned ENM_HI = 1012;
    localparam int unsigned LIV_LO = 1016;
    localparam int unsigned LIV_HI = 1020;
    localparam int unsigned BMB_LO = 1024;
    localparam int unsigned BMB_HI = 1028;

    localparam int NUM_REGIONS = 5;

    // Enable bit positions: {bombs, lives, enemies, ptr, mem}
    localparam int EN_MEM = 0;
    localparam int EN_PTR = 1;
    localparam int EN_ENM = 2;
    localparam int EN_LIV = 3;
    localparam int EN_BMB = 4;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef enum logic [2:0] {
        REG_MEM, REG_PTR, REG_ENEMIES, REG_LIVES, REG_BOMBS, REG_NONE
    } region_t;

    // Address compare done at 64 bits so any ADDR_W up to 64 works
    function automatic logic in_range(input logic [63:0] a,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (a >= 64'(lo)) && (a <= 64'(hi));
    endfunction

endpackage

// File: rtl/game_bus_arbiter_if.sv
// Requester and target signals of the shared game data bus.
interface game_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_err;

    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_en_mem;
    logic              bus_en_ptr;
    logic              bus_en_enemies;
    logic              bus_en_lives;
    logic              bus_en_bombs;
    logic [DATA_W-1:0] bus_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, bus_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
               vid_gnt, vid_rvalid, vid_rdata, vid_err,
               bus_addr, bus_we, bus_wdata,
               bus_en_mem, bus_en_ptr, bus_en_enemies, bus_en_lives, bus_en_bombs
    );

    // Requesters plus target side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, bus_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
               vid_gnt, vid_rvalid, vid_rdata, vid_err,
               bus_addr, bus_we, bus_wdata,
               bus_en_mem, bus_en_ptr, bus_en_enemies, bus_en_lives, bus_en_bombs
    );

endinterface

// File: rtl/game_region_decode.sv
// Combinational address decode into region id and one-hot enables.
module game_region_decode
    import game_bus_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]      addr,
    output region_t                region,
    output logic [NUM_REGIONS-1:0] en
);

    // First matching range wins; ranges are disjoint so order is cosmetic
    always_comb begin
        region = REG_NONE;
        en     = '0;
        if (in_range(64'(addr), MEM_LO, MEM_HI)) begin
            region     = REG_MEM;
            en[EN_MEM] = 1'b1;
        end else if (in_range(64'(addr), PTR_LO, PTR_HI)) begin
            region     = REG_PTR;
            en[EN_PTR] = 1'b1;
        end else if (in_range(64'(addr), ENM_LO, ENM_HI)) begin
            region     = REG_ENEMIES;
            en[EN_ENM] = 1'b1;
        end else if (in_range(64'(addr), LIV_LO, LIV_HI)) begin
            region     = REG_LIVES;
            en[EN_LIV] = 1'b1;
        end else if (in_range(64'(addr), BMB_LO, BMB_HI)) begin
            region     = REG_BOMBS;
            en[EN_BMB] = 1'b1;
        end
    end

endmodule

// File: rtl/game_bus_arbiter.sv
// Two-requester (CPU / video) arbiter for the game data bus with
// starvation guard, region decode and ADDR/DATA phase sequencing.
module game_bus_arbiter
    import game_bus_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int VID_MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    game_bus_arbiter_if.slave bus
);

    localparam int             CW      = $clog2(VID_MAX_WAIT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(VID_MAX_WAIT);

    state_t                 state;
    logic [CW-1:0]          starve_cnt;
    logic [NUM_REGIONS-1:0] en_q;
    logic [NUM_REGIONS-1:0] dec_en;
    region_t                region;
    logic                   vid_win;
    logic                   mapped;
    logic [ADDR_W-1:0]      sel_addr;

    // Video wins when CPU is absent or has starved video long enough
    always_comb begin
        vid_win  = bus.vid_req && (!bus.cpu_req || (starve_cnt == CNT_MAX));
        sel_addr = vid_win ? bus.vid_addr : bus.cpu_addr;
        mapped   = (region != REG_NONE);
    end

    game_region_decode #(.ADDR_W(ADDR_W)) u_dec (
        .addr   (sel_addr),
        .region (region),
        .en     (dec_en)
    );

    // FSM with registered grants/errors/rvalid; one-cycle pulses default low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            en_q           <= '0;
            bus.bus_addr   <= '0;
            bus.bus_we     <= 1'b0;
            bus.bus_wdata  <= '0;
            bus.cpu_gnt    <= 1'b0;
            bus.cpu_err    <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.vid_gnt    <= 1'b0;
            bus.vid_err    <= 1'b0;
            bus.vid_rvalid <= 1'b0;
        end else begin
            en_q           <= '0;
            bus.bus_we     <= 1'b0;
            bus.cpu_gnt    <= 1'b0;
            bus.cpu_err    <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.vid_gnt    <= 1'b0;
            bus.vid_err    <= 1'b0;
            bus.vid_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (vid_win || !bus.vid_req)
                        starve_cnt <= '0;
                    else if (bus.cpu_req && starve_cnt != CNT_MAX)
                        starve_cnt <= starve_cnt + 1'b1;
                    if (bus.cpu_req || bus.vid_req) begin
                        state         <= ADDR;
                        bus.bus_addr  <= sel_addr;
                        bus.bus_we    <= !vid_win && bus.cpu_we && mapped;
                        bus.bus_wdata <= vid_win ? '0 : bus.cpu_wdata;
                        en_q          <= dec_en;
                        bus.cpu_gnt   <= !vid_win;
                        bus.vid_gnt   <= vid_win;
                        bus.cpu_err   <= !vid_win && !mapped;
                        bus.vid_err   <= vid_win && !mapped;
                    end
                end
                ADDR: begin
                    // Only a mapped read needs a data phase
                    if (!bus.bus_we && en_q != '0) begin
                        state          <= DATA;
                        bus.cpu_rvalid <= bus.cpu_gnt;
                        bus.vid_rvalid <= bus.vid_gnt;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is a pass-through gated to the winner's data phase
    assign bus.cpu_rdata      = bus.cpu_rvalid ? bus.bus_rdata : {DATA_W{1'b0}};
    assign bus.vid_rdata      = bus.vid_rvalid ? bus.bus_rdata : {DATA_W{1'b0}};
    assign bus.bus_en_mem     = en_q[EN_MEM];
    assign bus.bus_en_ptr     = en_q[EN_PTR];
    assign bus.bus_en_enemies = en_q[EN_ENM];
    assign bus.bus_en_lives   = en_q[EN_LIV];
    assign bus.bus_en_bombs   = en_q[EN_BMB];

endmodule
